// File: rtl/sample_port_scheduler.sv
// Shares RAM port B between a small ADC sample write queue and VGA reads.
// VGA normally wins; the queue is forced through after STARVE_MAX VGA grants.
module sample_port_scheduler #(
  parameter int          DEPTH      = 4,
  parameter int          WRAP       = 640,
  parameter logic [11:0] EMG_BASE   = 12'hC7F,
  parameter logic [11:0] ECG_BASE   = 12'h801,
  parameter int          STARVE_MAX = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        adc_valid,
  input  logic        adc_chan,
  input  logic [31:0] adc_data,
  output logic        adc_ready,
  input  logic        vga_req,
  input  logic [11:0] vga_addr,
  output logic [31:0] vga_data,
  output logic        vga_data_valid,
  output logic        vga_miss,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic [9:0]  emg_index,
  output logic [9:0]  ecg_index,
  output logic [7:0]  drop_count,
  output logic [1:0]  sched_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_VGA = 2'd1,
    SERVE_ADC = 2'd2
  } state_t;

  state_t        state_q, grant;
  logic          vld_q;
  logic [43:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [9:0]    emg_idx_q, emg_idx_d, ecg_idx_q, ecg_idx_d;
  logic [7:0]    drop_q, drop_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          empty, full, push, pop, starved;
  logic [9:0]    sel_idx, inc_idx;
  logic [11:0]   entry_addr;
  logic [43:0]   head;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == (AW+1)'(DEPTH));
    push       = adc_valid && !full;
    starved    = (starve_q == SW'(STARVE_MAX)) && !empty;
    sel_idx    = adc_chan ? ecg_idx_q : emg_idx_q;
    inc_idx    = (sel_idx == 10'(WRAP - 1)) ? 10'd0 : sel_idx + 10'd1;
    // 12-bit sum truncates naturally, giving modulo-4096 addressing.
    entry_addr = (adc_chan ? ECG_BASE : EMG_BASE) + {2'b00, sel_idx};
    head       = mem_q[rd_ptr_q];

    if (starved)     grant = SERVE_ADC;
    else if (vga_req) grant = SERVE_VGA;
    else if (!empty) grant = SERVE_ADC;
    else             grant = IDLE;
    pop = (grant == SERVE_ADC);

    ram_we   = pop;
    ram_addr = pop ? head[43:32] : vga_addr;
    ram_din  = pop ? head[31:0] : 32'd0;
    vga_miss = starved && vga_req;

    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;

    emg_idx_d = (push && !adc_chan) ? inc_idx : emg_idx_q;
    ecg_idx_d = (push && adc_chan) ? inc_idx : ecg_idx_q;
    drop_d    = (adc_valid && full && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    starve_d = starve_q;
    if (empty || pop)             starve_d = '0;
    else if (grant == SERVE_VGA)  starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      vld_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      emg_idx_q <= '0;
      ecg_idx_q <= '0;
      drop_q    <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= grant;
      vld_q     <= (grant == SERVE_VGA);
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      emg_idx_q <= emg_idx_d;
      ecg_idx_q <= ecg_idx_d;
      drop_q    <= drop_d;
      starve_q  <= starve_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {entry_addr, adc_data};
  end

  assign adc_ready      = !full;
  assign vga_data_valid = vld_q;
  assign vga_data       = vld_q ? ram_dout : 32'd0;
  assign emg_index      = emg_idx_q;
  assign ecg_index      = ecg_idx_q;
  assign drop_count     = drop_q;
  assign sched_state    = grant;

endmodule

// File: tb/tb_sample_port_scheduler.sv
// Directed bench for sample_port_scheduler with a behavioural 4K x 32 RAM
// on port B; inputs change 1 ns after rising edges, outputs read on falling edges.
module tb_sample_port_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        adc_valid = 1'b0, adc_chan = 1'b0;
  logic [31:0] adc_data = '0;
  logic        vga_req = 1'b0;
  logic [11:0] vga_addr = '0;
  logic        adc_ready, vga_data_valid, vga_miss, ram_we;
  logic [31:0] vga_data, ram_din, ram_dout;
  logic [11:0] ram_addr;
  logic [9:0]  emg_index, ecg_index;
  logic [7:0]  drop_count;
  logic [1:0]  sched_state;
  logic [31:0] ram [4096];
  int          n_vec = 0, n_err = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  sample_port_scheduler dut (
    .clock(clock), .reset(reset), .adc_valid(adc_valid), .adc_chan(adc_chan),
    .adc_data(adc_data), .adc_ready(adc_ready), .vga_req(vga_req),
    .vga_addr(vga_addr), .vga_data(vga_data), .vga_data_valid(vga_data_valid),
    .vga_miss(vga_miss), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .emg_index(emg_index), .ecg_index(ecg_index),
    .drop_count(drop_count), .sched_state(sched_state)
  );

  task automatic drive(input logic v, input logic ch, input logic [31:0] d,
                       input logic rq, input logic [11:0] a);
    @(posedge clock); #1;
    adc_valid = v; adc_chan = ch; adc_data = d; vga_req = rq; vga_addr = a;
    @(negedge clock);
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 1'b1; adc_valid = 1'b0; vga_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_vec++; if (adc_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", adc_ready); end
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_we got %b want 0", ram_we); end
    n_vec++; if (vga_data_valid !== 1'b0) begin n_err++; $display("FAIL rst_vld got %b want 0", vga_data_valid); end
    n_vec++; if (vga_miss !== 1'b0) begin n_err++; $display("FAIL rst_miss got %b want 0", vga_miss); end
    n_vec++; if (vga_data !== 32'd0) begin n_err++; $display("FAIL rst_vdata got %h want 0", vga_data); end
    n_vec++; if (emg_index !== 10'd0 || ecg_index !== 10'd0) begin n_err++; $display("FAIL rst_idx got %0d/%0d want 0/0", emg_index, ecg_index); end
    n_vec++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL rst_drop got %0d want 0", drop_count); end
    n_vec++; if (sched_state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", sched_state); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b0, 32'h11, 1'b0, 12'h000);
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL basic_c0_we got %b want 0", ram_we); end
    drive(1'b1, 1'b1, 32'h22, 1'b0, 12'h000);
    n_vec++; if (ram_we !== 1'b1 || ram_addr !== 12'hC7F || ram_din !== 32'h11) begin
      n_err++; $display("FAIL basic_emg_wr got we=%b a=%h d=%h want 1/c7f/11", ram_we, ram_addr, ram_din); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 12'h000);
    n_vec++; if (ram_we !== 1'b1 || ram_addr !== 12'h801 || ram_din !== 32'h22) begin
      n_err++; $display("FAIL basic_ecg_wr got we=%b a=%h d=%h want 1/801/22", ram_we, ram_addr, ram_din); end
    n_vec++; if (emg_index !== 10'd1 || ecg_index !== 10'd1) begin n_err++; $display("FAIL basic_idx got %0d/%0d want 1/1", emg_index, ecg_index); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 12'h000);
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL basic_idle_we got %b want 0", ram_we); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 640; i++) begin
      drive(1'b1, 1'b0, 32'h1000 + i, 1'b0, 12'h000);
      if (i == 639) begin
        n_vec++; if (ram_we !== 1'b1 || ram_addr !== 12'hEFD || ram_din !== 32'h127E) begin
          n_err++; $display("FAIL wrap_639 got we=%b a=%h d=%h want 1/efd/127e", ram_we, ram_addr, ram_din); end
      end
    end
    drive(1'b1, 1'b0, 32'hABCD, 1'b0, 12'h000);
    n_vec++; if (ram_addr !== 12'hEFE || ram_din !== 32'h127F) begin
      n_err++; $display("FAIL wrap_640 got a=%h d=%h want efe/127f", ram_addr, ram_din); end
    n_vec++; if (emg_index !== 10'd0) begin n_err++; $display("FAIL wrap_idx0 got %0d want 0", emg_index); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 12'h000);
    n_vec++; if (ram_we !== 1'b1 || ram_addr !== 12'hC7F || ram_din !== 32'hABCD) begin
      n_err++; $display("FAIL wrap_641 got we=%b a=%h d=%h want 1/c7f/abcd", ram_we, ram_addr, ram_din); end
    n_vec++; if (emg_index !== 10'd1 || ecg_index !== 10'd0) begin n_err++; $display("FAIL wrap_idx1 got %0d/%0d want 1/0", emg_index, ecg_index); end
  endtask

  task automatic test_starve();
    apply_reset();
    drive(1'b1, 1'b0, 32'h55, 1'b1, 12'h010);
    n_vec++; if (sched_state !== 2'd1 || ram_we !== 1'b0) begin n_err++; $display("FAIL starve_c0 got st=%0d we=%b want 1/0", sched_state, ram_we); end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 12'h010);
      n_vec++; if (ram_we !== 1'b0 || vga_miss !== 1'b0 || ram_addr !== 12'h010) begin
        n_err++; $display("FAIL starve_vga%0d got we=%b miss=%b a=%h want 0/0/010", i, ram_we, vga_miss, ram_addr); end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 12'h010);
    n_vec++; if (ram_we !== 1'b1 || vga_miss !== 1'b1 || ram_addr !== 12'hC7F || ram_din !== 32'h55) begin
      n_err++; $display("FAIL starve_force got we=%b miss=%b a=%h d=%h want 1/1/c7f/55", ram_we, vga_miss, ram_addr, ram_din); end
    n_vec++; if (sched_state !== 2'd2) begin n_err++; $display("FAIL starve_state got %0d want 2", sched_state); end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 12'h010);
    n_vec++; if (ram_we !== 1'b0 || vga_miss !== 1'b0 || vga_data_valid !== 1'b0) begin
      n_err++; $display("FAIL starve_resume got we=%b miss=%b vld=%b want 0/0/0", ram_we, vga_miss, vga_data_valid); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 12'h010);
    n_vec++; if (vga_data_valid !== 1'b1) begin n_err++; $display("FAIL starve_vld got %b want 1", vga_data_valid); end
  endtask

  task automatic test_vga_read();
    apply_reset();
    ram[12'h100] = 32'hDEAD;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 12'h100);
    n_vec++; if (ram_we !== 1'b0 || ram_addr !== 12'h100 || vga_data_valid !== 1'b0) begin
      n_err++; $display("FAIL vga_req got we=%b a=%h vld=%b want 0/100/0", ram_we, ram_addr, vga_data_valid); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 12'h100);
    n_vec++; if (vga_data_valid !== 1'b1 || vga_data !== 32'hDEAD) begin
      n_err++; $display("FAIL vga_data got vld=%b d=%h want 1/dead", vga_data_valid, vga_data); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 12'h100);
    n_vec++; if (vga_data_valid !== 1'b0 || vga_data !== 32'h0) begin
      n_err++; $display("FAIL vga_after got vld=%b d=%h want 0/0", vga_data_valid, vga_data); end
  endtask

  task automatic test_overflow();
    logic [11:0] exp_a [5];
    logic [31:0] exp_d [5];
    exp_a = '{12'hC7F, 12'hC80, 12'hC81, 12'hC82, 12'h801};
    exp_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB7};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'hA0 + i, 1'b1, 12'h040);
      n_vec++; if (adc_ready !== (i < 4) || ram_we !== 1'b0) begin
        n_err++; $display("FAIL ovf_fill%0d got rdy=%b we=%b want %b/0", i, adc_ready, ram_we, i < 4); end
    end
    for (int i = 0; i < 5; i++) begin
      drive(i < 2, 1'b1, 32'hB6 + i, 1'b0, 12'h040);
      n_vec++; if (ram_we !== 1'b1 || ram_addr !== exp_a[i] || ram_din !== exp_d[i]) begin
        n_err++; $display("FAIL ovf_wr%0d got we=%b a=%h d=%h want 1/%h/%h", i, ram_we, ram_addr, ram_din, exp_a[i], exp_d[i]); end
      if (i == 0) begin
        n_vec++; if (adc_ready !== 1'b0 || drop_count !== 8'd2) begin
          n_err++; $display("FAIL ovf_full got rdy=%b drops=%0d want 0/2", adc_ready, drop_count); end
      end
      if (i == 1) begin
        n_vec++; if (adc_ready !== 1'b1 || drop_count !== 8'd3) begin
          n_err++; $display("FAIL ovf_pop got rdy=%b drops=%0d want 1/3", adc_ready, drop_count); end
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 12'h040);
    n_vec++; if (ram_we !== 1'b0 || emg_index !== 10'd4 || ecg_index !== 10'd1) begin
      n_err++; $display("FAIL ovf_end got we=%b idx=%0d/%0d want 0/4/1", ram_we, emg_index, ecg_index); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'hE0 + i, 1'b1, 12'h020);
    @(posedge clock); #1;
    reset = 1'b1; adc_valid = 1'b0; vga_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_vec++; if (ram_we !== 1'b0 || adc_ready !== 1'b1 || emg_index !== 10'd0) begin
        n_err++; $display("FAIL rmid_hold%0d got we=%b rdy=%b idx=%0d want 0/1/0", i, ram_we, adc_ready, emg_index); end
      if (i == 0) begin @(posedge clock); #1; end
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rmid_nowr got we=%b want 0", ram_we); end
    drive(1'b1, 1'b1, 32'hC1, 1'b0, 12'h020);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 12'h020);
    n_vec++; if (ram_we !== 1'b1 || ram_addr !== 12'h801 || ram_din !== 32'hC1) begin
      n_err++; $display("FAIL rmid_first got we=%b a=%h d=%h want 1/801/c1", ram_we, ram_addr, ram_din); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_starve();
    test_vga_read();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
